icache_direct: RTL

- Direct-mapped, read-only instruction cache between the fetch stage and the memory arbiter.
- Serves 32-bit instruction windows at any halfword-aligned PC, so RVC (compressed) streams are supported.
- A window that straddles two words, or two lines, is assembled from both.
- Hit path is combinational from pc_in. Misses refill a whole line, one word-read at a time, from the arbiter.

---
 rtl/icache_direct_pkg.sv | 14 +
 rtl/icache_direct_if.sv | 23 ++
 rtl/icache_direct_lookup.sv | 41 ++++
 rtl/icache_direct.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/icache_direct_pkg.sv
// Shared constants and state encoding for the direct-mapped instruction cache.
package icache_direct_pkg;

    localparam int ICACHE_INDEX_BITS       = 4;
    localparam int ICACHE_OFFSET_WORD_BITS = 2;
    localparam int ICACHE_TAG_BITS         = 32 - ICACHE_INDEX_BITS - ICACHE_OFFSET_WORD_BITS - 2;
    localparam int RVC_HALF_BITS           = 16;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_REFILL = 1'b1
    } icache_state_e;

endpackage

// File: rtl/icache_direct_if.sv
// Fetch-side and arbiter-side signals of the instruction cache, bundled together.
interface icache_direct_if;

    logic        fetch_ready_in;
    logic [31:0] pc_in;
    logic        inst_ready_out;
    logic [31:0] inst_out;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic        mem_done;
    logic [31:0] mem_data;

    modport master (
        output fetch_ready_in, pc_in, mem_done, mem_data,
        input  inst_ready_out, inst_out, mem_valid, mem_addr
    );

    modport slave (
        input  fetch_ready_in, pc_in, mem_done, mem_data,
        output inst_ready_out, inst_out, mem_valid, mem_addr
    );

endinterface

// File: rtl/icache_direct_lookup.sv
// Combinational tag compare and 32-bit window assembly across the line holding pc
// and the line holding pc+4.
module icache_direct_lookup
    import icache_direct_pkg::*;
#(
    parameter int INDEX_BITS       = ICACHE_INDEX_BITS,
    parameter int OFFSET_WORD_BITS = ICACHE_OFFSET_WORD_BITS,
    localparam int TAG_BITS        = 32 - INDEX_BITS - OFFSET_WORD_BITS - 2,
    localparam int WORDS           = 1 << OFFSET_WORD_BITS
) (
    input  logic [TAG_BITS-1:0]         pc_tag,
    input  logic [TAG_BITS-1:0]         pc_hi_tag,
    input  logic [OFFSET_WORD_BITS-1:0] offset,
    input  logic                        half_sel,
    input  logic                        valid_lo,
    input  logic [TAG_BITS-1:0]         tag_lo,
    input  logic [WORDS-1:0][31:0]      line_lo,
    input  logic                        valid_hi,
    input  logic [TAG_BITS-1:0]         tag_hi,
    input  logic [WORDS-1:0][31:0]      line_hi,
    output logic                        hit_lo,
    output logic                        hit_hi,
    output logic                        need_hi,
    output logic [31:0]                 window
);

    logic [OFFSET_WORD_BITS-1:0] offset_next;
    logic [31:0]                 word_a;
    logic [31:0]                 word_b;

    assign offset_next = offset + OFFSET_WORD_BITS'(1);
    assign hit_lo      = valid_lo && (tag_lo == pc_tag);
    assign hit_hi      = valid_hi && (tag_hi == pc_hi_tag);
    // Only an odd-halfword PC in the last word of a line reaches into the next line.
    assign need_hi     = half_sel && (offset == {OFFSET_WORD_BITS{1'b1}});

    assign word_a = line_lo[offset];
    assign word_b = need_hi ? line_hi[0] : line_lo[offset_next];
    assign window = half_sel ? {word_b[RVC_HALF_BITS-1:0], word_a[31:RVC_HALF_BITS]} : word_a;

endmodule

// File: rtl/icache_direct.sv
// Direct-mapped read-only instruction cache with halfword-granular fetch windows.
// Define ICACHE_STATS_EN to add the hit_count / miss_count statistics ports.
module icache_direct
    import icache_direct_pkg::*;
#(
    parameter int INDEX_BITS       = ICACHE_INDEX_BITS,
    parameter int OFFSET_WORD_BITS = ICACHE_OFFSET_WORD_BITS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
`ifdef ICACHE_STATS_EN
    output logic [31:0] hit_count,
    output logic [31:0] miss_count,
`endif
    icache_direct_if.slave bus
);

    localparam int LINES    = 1 << INDEX_BITS;
    localparam int WORDS    = 1 << OFFSET_WORD_BITS;
    localparam int LINE_LSB = OFFSET_WORD_BITS + 2;
    localparam int TAG_BITS = 32 - INDEX_BITS - LINE_LSB;

    logic [LINES-1:0]     valid_reg;
    logic [TAG_BITS-1:0]  tag_reg  [LINES];
    logic [WORDS-1:0][31:0] data_reg [LINES];

    icache_state_e               state_reg, state_next;
    logic [OFFSET_WORD_BITS-1:0] count_reg, count_next;
    logic [31-LINE_LSB:0]        line_reg, line_next;

    logic [31:0]           pc_hi;
    logic [INDEX_BITS-1:0] index_lo, index_hi, refill_index;
    logic                  hit_lo, hit_hi, need_hi, ready;
    logic [31:0]           window;
    logic                  start_refill, word_we, last_word;
    logic                  unused_bits;

    assign pc_hi        = {bus.pc_in[31:2] + 30'd1, 2'b00};
    assign index_lo     = bus.pc_in[LINE_LSB +: INDEX_BITS];
    assign index_hi     = pc_hi[LINE_LSB +: INDEX_BITS];
    assign refill_index = line_reg[INDEX_BITS-1:0];
    assign unused_bits  = ^{bus.pc_in[0], pc_hi[LINE_LSB-1:0]};

    icache_direct_lookup #(
        .INDEX_BITS       (INDEX_BITS),
        .OFFSET_WORD_BITS (OFFSET_WORD_BITS)
    ) u_lookup (
        .pc_tag    (bus.pc_in[31 -: TAG_BITS]),
        .pc_hi_tag (pc_hi[31 -: TAG_BITS]),
        .offset    (bus.pc_in[2 +: OFFSET_WORD_BITS]),
        .half_sel  (bus.pc_in[1]),
        .valid_lo  (valid_reg[index_lo]),
        .tag_lo    (tag_reg[index_lo]),
        .line_lo   (data_reg[index_lo]),
        .valid_hi  (valid_reg[index_hi]),
        .tag_hi    (tag_reg[index_hi]),
        .line_hi   (data_reg[index_hi]),
        .hit_lo    (hit_lo),
        .hit_hi    (hit_hi),
        .need_hi   (need_hi),
        .window    (window)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            count_reg <= '0;
            line_reg  <= '0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            line_reg  <= line_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        count_next    = count_reg;
        line_next     = line_reg;
        start_refill  = 1'b0;
        word_we       = 1'b0;
        last_word     = 1'b0;
        ready         = 1'b0;
        bus.mem_valid = 1'b0;
        bus.mem_addr  = '0;
        case (state_reg)
            ST_IDLE: begin
                ready = hit_lo && (!need_hi || hit_hi);
                if (rdy && bus.fetch_ready_in && !ready) begin
                    start_refill = 1'b1;
                    state_next   = ST_REFILL;
                    count_next   = '0;
                    // The lower line is fetched first when both halves of a window miss.
                    line_next    = hit_lo ? pc_hi[31:LINE_LSB] : bus.pc_in[31:LINE_LSB];
                end
            end
            ST_REFILL: begin
                bus.mem_valid = 1'b1;
                bus.mem_addr  = {line_reg, count_reg, 2'b00};
                if (rdy && bus.mem_done) begin
                    word_we    = 1'b1;
                    last_word  = &count_reg;
                    count_next = count_reg + OFFSET_WORD_BITS'(1);
                    if (last_word) begin
                        state_next = ST_IDLE;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign bus.inst_ready_out = ready;
    assign bus.inst_out       = ready ? window : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_reg <= '0;
        end else if (start_refill) begin
            valid_reg[line_next[INDEX_BITS-1:0]] <= 1'b0;
        end else if (word_we && last_word) begin
            valid_reg[refill_index] <= 1'b1;
        end
    end

    // Tags and data are not reset; valid_reg alone qualifies them.
    always_ff @(posedge clk) begin
        if (!rst && word_we) begin
            data_reg[refill_index][count_reg] <= bus.mem_data;
            if (last_word) begin
                tag_reg[refill_index] <= line_reg[31-LINE_LSB -: TAG_BITS];
            end
        end
    end

`ifdef ICACHE_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (rdy && bus.fetch_ready_in && ready) begin
                hit_count <= hit_count + 32'd1;
            end
            if (start_refill) begin
                miss_count <= miss_count + 32'd1;
            end
        end
    end
`else
    // Statistics are compiled out in this build; the cache adds no counter state.
`endif

endmodule
